pattern_scan_engine: RTL and testbench

//  Hardware engine for the program-3 workload. It sits beside data memory (dm1) on a second memory port.
//  On start it reads the 5-bit pattern from PAT_ADDR, then streams NUM_BYTES message bytes starting at BASE_ADDR.
//  It writes three 8-bit counts to RES_ADDR..RES_ADDR+2, then raises done:
//    in-byte matches, bytes holding at least one match, matches over the whole bit string (byte crossings included).

---
 rtl/pattern_scan_engine_if.sv | 28 ++
 rtl/pattern_scan_engine.sv | 153 +++++++++++++++
 tb/tb_pattern_scan_engine.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/pattern_scan_engine_if.sv
// Memory-port and start/done bundle between pattern_scan_engine (master) and its
// memory/controller side (slave).
interface pattern_scan_engine_if;
    logic       start;
    logic       done;
    logic [7:0] mem_addr;
    logic [7:0] mem_rd_data;
    logic       mem_wr_en;
    logic [7:0] mem_wr_data;

    modport master (
        input  start,
        input  mem_rd_data,
        output done,
        output mem_addr,
        output mem_wr_en,
        output mem_wr_data
    );

    modport slave (
        output start,
        output mem_rd_data,
        input  done,
        input  mem_addr,
        input  mem_wr_en,
        input  mem_wr_data
    );
endinterface

// File: rtl/pattern_scan_engine.sv
// Scans NUM_BYTES message bytes for a 5-bit pattern and writes three match counts to memory.
// Optional macro PSE_CROSS_COUNT_EN builds the byte-crossing window logic and the cts counter.
module pattern_scan_engine #(
    parameter logic [7:0] BASE_ADDR = 8'd0,
    parameter int         NUM_BYTES = 32,
    parameter logic [7:0] PAT_ADDR  = 8'd32,
    parameter logic [7:0] RES_ADDR  = 8'd33
) (
    input  logic                  clk,
    input  logic                  reset,
    pattern_scan_engine_if.master bus
);

    typedef enum logic [2:0] {
        IDLE, LOADP, SCAN, WR0, WR1, WR2, DONE
    } state_t;

    localparam logic [5:0] LAST_IDX = 6'(NUM_BYTES - 1);

    state_t     r_state;
    logic [4:0] r_pat;
    logic [5:0] r_idx;
    logic [7:0] r_ctb;
    logic [7:0] r_cto;
    logic       r_done;
    logic [7:0] r_mem_addr;
    logic       r_mem_wr_en;
    logic [7:0] r_mem_wr_data;

    logic [7:0] w_cur;
    logic [2:0] w_m_in;
    logic [7:0] w_ctb_nxt;
    logic [7:0] w_cto_nxt;
    logic [7:0] w_cts_wr;

    // Counts pattern hits among the four 5-bit windows of an 8-bit slice.
    function automatic logic [2:0] count_windows(input logic [7:0] s, input logic [4:0] p);
        logic [2:0] n;
        n = 3'd0;
        for (int k = 0; k < 4; k++) begin
            if (s[k +: 5] == p) n = n + 3'd1;
        end
        return n;
    endfunction

    assign w_cur     = bus.mem_rd_data;
    assign w_m_in    = count_windows(w_cur, r_pat);
    assign w_ctb_nxt = r_ctb + 8'(w_m_in);
    assign w_cto_nxt = r_cto + {7'd0, (w_m_in != 3'd0)};

`ifdef PSE_CROSS_COUNT_EN
    logic [7:0] r_cts;
    logic [3:0] r_prev;
    logic [2:0] w_m_x;
    logic [7:0] w_cts_nxt;

    // Windows straddling the byte boundary are w[11:4] of {prev[3:0], cur}.
    assign w_m_x     = (r_idx == 6'd0) ? 3'd0 : count_windows({r_prev, w_cur[7:4]}, r_pat);
    assign w_cts_nxt = r_cts + 8'(w_m_in) + 8'(w_m_x);
    assign w_cts_wr  = r_cts;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cts  <= 8'd0;
            r_prev <= 4'd0;
        end else if (r_state == LOADP) begin
            r_cts  <= 8'd0;
            r_prev <= 4'd0;
        end else if (r_state == SCAN) begin
            r_cts  <= w_cts_nxt;
            r_prev <= w_cur[3:0];
        end
    end
`else
    assign w_cts_wr = 8'h00;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= IDLE;
            r_pat         <= 5'd0;
            r_idx         <= 6'd0;
            r_ctb         <= 8'd0;
            r_cto         <= 8'd0;
            r_done        <= 1'b0;
            r_mem_addr    <= 8'd0;
            r_mem_wr_en   <= 1'b0;
            r_mem_wr_data <= 8'd0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.start) begin
                        r_state    <= LOADP;
                        r_mem_addr <= PAT_ADDR;
                    end
                end
                LOADP: begin
                    r_pat      <= w_cur[4:0];
                    r_ctb      <= 8'd0;
                    r_cto      <= 8'd0;
                    r_idx      <= 6'd0;
                    r_mem_addr <= BASE_ADDR;
                    r_state    <= SCAN;
                end
                SCAN: begin
                    r_ctb <= w_ctb_nxt;
                    r_cto <= w_cto_nxt;
                    // Final byte: the first result write carries the just-updated ctb.
                    if (r_idx == LAST_IDX) begin
                        r_state       <= WR0;
                        r_mem_addr    <= RES_ADDR;
                        r_mem_wr_en   <= 1'b1;
                        r_mem_wr_data <= w_ctb_nxt;
                    end else begin
                        r_idx      <= r_idx + 6'd1;
                        r_mem_addr <= BASE_ADDR + 8'(r_idx) + 8'd1;
                    end
                end
                WR0: begin
                    r_mem_addr    <= RES_ADDR + 8'd1;
                    r_mem_wr_data <= r_cto;
                    r_state       <= WR1;
                end
                WR1: begin
                    r_mem_addr    <= RES_ADDR + 8'd2;
                    r_mem_wr_data <= w_cts_wr;
                    r_state       <= WR2;
                end
                WR2: begin
                    r_mem_addr    <= 8'd0;
                    r_mem_wr_en   <= 1'b0;
                    r_mem_wr_data <= 8'd0;
                    r_done        <= 1'b1;
                    r_state       <= DONE;
                end
                DONE: begin
                    if (bus.start) begin
                        r_done     <= 1'b0;
                        r_mem_addr <= PAT_ADDR;
                        r_state    <= LOADP;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.done        = r_done;
    assign bus.mem_addr    = r_mem_addr;
    assign bus.mem_wr_en   = r_mem_wr_en;
    assign bus.mem_wr_data = r_mem_wr_data;

endmodule

// File: tb/tb_pattern_scan_engine.sv
// Directed bench for pattern_scan_engine with a behavioural 256-byte memory
// on its port; expected counts are worked out by hand for each vector.
module tb_pattern_scan_engine;

    logic clk;
    logic reset;
    logic [7:0] mem [256];
    int wr_cnt;
    int n_chk;
    int n_pass;

`ifdef PSE_CROSS_COUNT_EN
    localparam bit CROSS = 1'b1;
`else
    localparam bit CROSS = 1'b0;
`endif

    pattern_scan_engine_if bus ();

    pattern_scan_engine dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    assign bus.mem_rd_data = mem[bus.mem_addr];

    always @(posedge clk) begin
        if (bus.mem_wr_en) begin
            mem[bus.mem_addr] = bus.mem_wr_data;
            wr_cnt = wr_cnt + 1;
        end
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic load_mem(input logic [7:0] pat, input logic [7:0] b);
        for (int i = 0; i < 32; i++) mem[i] = b;
        mem[32] = pat;
        mem[33] = 8'hEE;
        mem[34] = 8'hEE;
        mem[35] = 8'hEE;
        wr_cnt = 0;
    endtask

    // Starts a run, waits for done, checks latency, write count and results.
    task automatic run_case(input string tag, input bit hold,
                            input int e_ctb, input int e_cto, input int e_cts);
        int edges;
        @(negedge clk);
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        if (!hold) bus.start = 1'b0;
        edges = 0;
        while (!bus.done && edges < 200) begin
            @(posedge clk);
            #1;
            edges++;
        end
        check({tag, "_latency"}, edges, 36);
        check({tag, "_wr_cnt"}, wr_cnt, 3);
        check({tag, "_ctb"}, int'(mem[33]), e_ctb);
        check({tag, "_cto"}, int'(mem[34]), e_cto);
        check({tag, "_cts"}, int'(mem[35]), CROSS ? e_cts : 0);
        bus.start = 1'b0;
    endtask

    initial begin
        n_chk = 0;
        n_pass = 0;
        wr_cnt = 0;
        bus.start = 1'b0;
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_done", int'(bus.done), 0);
        check("rst_wr_en", int'(bus.mem_wr_en), 0);
        check("rst_addr", int'(bus.mem_addr), 0);
        check("rst_wr_data", int'(bus.mem_wr_data), 0);
        @(negedge clk);
        reset = 1'b0;

        load_mem(8'h07, 8'hC1);
        run_case("c1", 1'b0, 0, 0, 31);

        load_mem(8'h00, 8'h00);
        run_case("c2", 1'b0, 128, 32, 252);

        load_mem(8'h15, 8'h55);
        run_case("c3", 1'b0, 64, 32, 126);
        load_mem(8'hF5, 8'h55);
        run_case("c3_hi", 1'b0, 64, 32, 126);

        load_mem(8'h00, 8'hFF);
        run_case("c4", 1'b0, 0, 0, 0);
        repeat (5) @(posedge clk);
        #1;
        check("c4_done_held", int'(bus.done), 1);
        load_mem(8'h00, 8'hFF);
        run_case("c4_again", 1'b0, 0, 0, 0);

        // Reset while the engine is reading byte 10.
        load_mem(8'h07, 8'hC1);
        @(negedge clk);
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        for (int e = 0; e < 40 && bus.mem_addr != 8'd10; e++) begin
            @(posedge clk);
            #1;
        end
        check("c5_at_idx10", int'(bus.mem_addr), 10);
        reset = 1'b1;
        #1;
        check("c5_done", int'(bus.done), 0);
        check("c5_wr_en", int'(bus.mem_wr_en), 0);
        check("c5_addr", int'(bus.mem_addr), 0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        repeat (40) @(posedge clk);
        #1;
        check("c5_no_writes", wr_cnt, 0);
        check("c5_idle_done", int'(bus.done), 0);
        check("c5_res_kept", int'(mem[33]), 8'hEE);
        load_mem(8'h07, 8'hC1);
        run_case("c5_rerun", 1'b0, 0, 0, 31);

        // start held high for the whole run.
        load_mem(8'h15, 8'h55);
        run_case("c6_hold", 1'b1, 64, 32, 126);
        repeat (40) @(posedge clk);
        #1;
        check("c6_no_retrig", wr_cnt, 3);
        check("c6_done_held", int'(bus.done), 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
